// File: rtl/lzc_pkg.sv
// ----------------------------------------------------------------------------
// lzc_pkg : shared sizing helpers for the leading-zero count / normalise path.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lzc_pkg;

   // Count width able to hold every value 0..width inclusive.
   function automatic int lzc_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   // Largest power of two strictly below width (width >= 2): the upper half.
   function automatic int lzc_upper_half(input int width);
      return 1 << ($clog2(width) - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lzc_tree.sv
// ----------------------------------------------------------------------------
// lzc_tree : combinational leading-zero counter built by recursive halving.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lzc_tree
   import lzc_pkg::*;
#(
   parameter int  WIDTH = 48,
   localparam int CNT_W = lzc_cnt_w(WIDTH)
) (
   input  logic [WIDTH-1:0] i_data,
   output logic [CNT_W-1:0] o_count,
   output logic             o_zero
);

   generate
      if (WIDTH == 1) begin : g_leaf
         assign o_count = ~i_data;
         assign o_zero  = ~i_data[0];
      end else begin : g_node
         // A power-of-two upper half with a remainder lower half behaves the
         // same as padding the operand with ones below its LSB.
         localparam int HALF  = lzc_upper_half(WIDTH);
         localparam int LO_W  = WIDTH - HALF;
         localparam int HI_CW = lzc_cnt_w(HALF);
         localparam int LO_CW = lzc_cnt_w(LO_W);

         logic [HI_CW-1:0] hi_count;
         logic [LO_CW-1:0] lo_count;
         logic             hi_zero;
         logic             lo_zero;

         lzc_tree #(
            .WIDTH (HALF)
         ) u_hi (
            .i_data  (i_data[WIDTH-1 -: HALF]),
            .o_count (hi_count),
            .o_zero  (hi_zero)
         );

         lzc_tree #(
            .WIDTH (LO_W)
         ) u_lo (
            .i_data  (i_data[LO_W-1:0]),
            .o_count (lo_count),
            .o_zero  (lo_zero)
         );

         always_comb begin
            o_count = CNT_W'(hi_count);
            if (hi_zero) begin
               o_count = CNT_W'(HALF) + CNT_W'(lo_count);
            end
         end

         assign o_zero = hi_zero & lo_zero;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/lzc_norm_pipe.sv
// ----------------------------------------------------------------------------
// lzc_norm_pipe : 2-stage elastic leading-zero count + normalising shifter.
// Optional zero-operand statistic counter under macro LZC_ZERO_STAT_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lzc_norm_pipe
   import lzc_pkg::*;
#(
   parameter int  WIDTH  = 48,
   parameter int  ZCNT_W = 16,
   localparam int CNT_W  = lzc_cnt_w(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [CNT_W-1:0] o_count,
   output logic [WIDTH-1:0] o_data,
   output logic             o_zero
`ifdef LZC_ZERO_STAT_EN
   ,
   output logic [ZCNT_W-1:0] o_zero_cnt
`endif
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [CNT_W-1:0] count;
      logic             zero;
   } stage_t;

   generate
      if (WIDTH < 2 || ZCNT_W < 1) begin : g_param_check
         $error("lzc_norm_pipe: WIDTH must be >= 2 and ZCNT_W >= 1");
      end
   endgenerate

   stage_t           s1_q, s1_d;
   stage_t           s2_q, s2_d;
   logic             v1_q, v2_q;
   logic             s1_load, s2_load;
   logic [CNT_W-1:0] tree_count;
   logic             tree_zero;

   lzc_tree #(
      .WIDTH (WIDTH)
   ) u_tree (
      .i_data  (i_data),
      .o_count (tree_count),
      .o_zero  (tree_zero)
   );

   // Each stage may load when its own slot is free or is emptying this cycle.
   always_comb begin
      s2_load = !v2_q || i_ready;
      s1_load = !v1_q || s2_load;
   end

   always_comb begin
      s1_d = s1_q;
      if (s1_load && i_valid) begin
         s1_d.data  = i_data;
         s1_d.count = tree_count;
         s1_d.zero  = tree_zero;
      end
   end

   always_comb begin
      s2_d = s2_q;
      if (s2_load && v1_q) begin
         s2_d.data  = s1_q.data << s1_q.count;
         s2_d.count = s1_q.count;
         s2_d.zero  = s1_q.zero;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         if (s1_load) begin
            v1_q <= i_valid;
         end
         if (s2_load) begin
            v2_q <= v1_q;
         end
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign o_ready = s1_load;
   assign o_valid = v2_q;
   assign o_count = s2_q.count;
   assign o_data  = s2_q.data;
   assign o_zero  = s2_q.zero;

`ifdef LZC_ZERO_STAT_EN
   logic [ZCNT_W-1:0] zcnt_q, zcnt_d;

   // Saturating count of all-zero results actually taken downstream.
   always_comb begin
      zcnt_d = zcnt_q;
      if (v2_q && i_ready && s2_q.zero && (zcnt_q != {ZCNT_W{1'b1}})) begin
         zcnt_d = zcnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         zcnt_q <= '0;
      end else begin
         zcnt_q <= zcnt_d;
      end
   end

   assign o_zero_cnt = zcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lzc_norm_pipe.sv
// ----------------------------------------------------------------------------
// tb_lzc_norm_pipe : directed + random bench for lzc_norm_pipe at widths 48/53/24.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lzc_norm_pipe;

   localparam int NI = 3;
   localparam int WS [NI] = '{48, 53, 24};

   typedef struct {
      logic [63:0] data;
      int          count;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vin = 1'b0;
   logic        rdy = 1'b1;
   logic [63:0] din [NI];
   logic        ov  [NI];
   logic        ordy[NI];
   logic        oz  [NI];
   logic [63:0] od  [NI];
   logic [63:0] oc  [NI];
   logic [63:0] zc  [NI];

   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;
   exp_t sbq [NI][$];
   logic [63:0] hd [NI];
   logic [63:0] hc [NI];
   logic        hz [NI];
   bit          hold [NI];
   int          zmodel [NI];
   bit          last_acc;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = WS[g];
      logic [W-1:0]             d;
      logic [$clog2(W+1)-1:0]   c;
`ifdef LZC_ZERO_STAT_EN
      logic [15:0]              z;
`endif
      lzc_norm_pipe #(
         .WIDTH (W)
      ) u_dut (
         .i_clk   (clk),
         .i_rst   (rst),
         .i_valid (vin),
         .o_ready (ordy[g]),
         .i_data  (din[g][W-1:0]),
         .o_valid (ov[g]),
         .i_ready (rdy),
         .o_count (c),
         .o_data  (d),
         .o_zero  (oz[g])
`ifdef LZC_ZERO_STAT_EN
         ,
         .o_zero_cnt (z)
`endif
      );
      assign od[g] = 64'(d);
      assign oc[g] = 64'(c);
`ifdef LZC_ZERO_STAT_EN
      assign zc[g] = 64'(z);
`else
      assign zc[g] = 64'd0;
`endif
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: scan for the highest set bit, then shift arithmetically.
   function automatic exp_t model(input logic [63:0] v, input int w);
      exp_t        e;
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      e.count = w;
      for (int i = 0; i < w; i++) begin
         if (v[i]) e.count = w - 1 - i;
      end
      e.data = ((v & m) << e.count) & m;
      e.zero = (e.count == w);
      return e;
   endfunction

   task automatic chk_out(input int k, input int cnt, input logic [63:0] data, input logic zero);
      check($sformatf("valid_w%0d", WS[k]), 64'(ov[k]), 64'd1);
      check($sformatf("count_w%0d", WS[k]), oc[k], 64'(cnt));
      check($sformatf("data_w%0d", WS[k]), od[k], data);
      check($sformatf("zero_w%0d", WS[k]), 64'(oz[k]), 64'(zero));
   endtask

   // One clock: sample, score results, record stalls and accepted operands.
   task automatic tick();
      exp_t e;
      #1;
      last_acc = vin && ordy[0];
      for (int k = 0; k < NI; k++) begin
         if (hold[k]) begin
            check($sformatf("hold_valid_w%0d", WS[k]), 64'(ov[k]), 64'd1);
            check($sformatf("hold_data_w%0d", WS[k]), od[k], hd[k]);
            check($sformatf("hold_count_w%0d", WS[k]), oc[k], hc[k]);
            check($sformatf("hold_zero_w%0d", WS[k]), 64'(oz[k]), 64'(hz[k]));
         end
`ifdef LZC_ZERO_STAT_EN
         check($sformatf("zero_cnt_w%0d", WS[k]), zc[k], 64'(zmodel[k]));
`endif
         if (ov[k] && rdy) begin
            check($sformatf("sb_nonempty_w%0d", WS[k]), 64'(sbq[k].size() != 0), 64'd1);
            if (sbq[k].size() != 0) begin
               e = sbq[k].pop_front();
               check($sformatf("sb_count_w%0d", WS[k]), oc[k], 64'(e.count));
               check($sformatf("sb_data_w%0d", WS[k]), od[k], e.data);
               check($sformatf("sb_zero_w%0d", WS[k]), 64'(oz[k]), 64'(e.zero));
               if (e.zero && zmodel[k] < 65535) zmodel[k]++;
            end
         end
         hold[k] = ov[k] && !rdy;
         hd[k]   = od[k];
         hc[k]   = oc[k];
         hz[k]   = oz[k];
         if (vin && ordy[k]) sbq[k].push_back(model(din[k], WS[k]));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic single(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      din[0] = a; din[1] = b; din[2] = c;
      vin = 1'b1;
      rdy = 1'b1;
      tick();
      vin = 1'b0;
      for (int k = 0; k < NI; k++) check($sformatf("lat1_w%0d", WS[k]), 64'(ov[k]), 64'd0);
      tick();
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         din[k] = '0; hold[k] = 0; zmodel[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("rst_valid_w%0d", WS[k]), 64'(ov[k]), 64'd0);
         check($sformatf("rst_ready_w%0d", WS[k]), 64'(ordy[k]), 64'd1);
         check($sformatf("rst_count_w%0d", WS[k]), oc[k], 64'd0);
         check($sformatf("rst_data_w%0d", WS[k]), od[k], 64'd0);
         check($sformatf("rst_zero_w%0d", WS[k]), 64'(oz[k]), 64'd0);
      end

      // Mid-word leading one
      single(64'h0000_0080_0000, 64'h0000_0080_0000, 64'h00_0100);
      chk_out(0, 24, 64'h8000_0000_0000, 1'b0);
      chk_out(1, 29, 64'h10_0000_0000_0000, 1'b0);
      chk_out(2, 15, 64'h80_0000, 1'b0);
      tick();

      // LSB-only and all-zero operands
      single(64'd1, 64'd1, 64'd1);
      chk_out(0, 47, 64'h8000_0000_0000, 1'b0);
      chk_out(1, 52, 64'h10_0000_0000_0000, 1'b0);
      chk_out(2, 23, 64'h80_0000, 1'b0);
      tick();
      single(64'd0, 64'd0, 64'd0);
      for (int k = 0; k < NI; k++) chk_out(k, WS[k], 64'd0, 1'b1);
      tick();
`ifdef LZC_ZERO_STAT_EN
      for (int k = 0; k < NI; k++) check($sformatf("zcnt1_w%0d", WS[k]), zc[k], 64'd1);
`endif

      // Back-to-back stream, full throughput
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b_ready_%0d", i), 64'(ordy[0]), 64'd1);
         for (int k = 0; k < NI; k++) din[k] = 64'd1 << (WS[k] - 1 - i);
         vin = 1'b1;
         tick();
      end
      vin = 1'b0;
      for (int k = 0; k < NI; k++) chk_out(k, 1, 64'd1 << (WS[k] - 1), 1'b0);
      tick();
      for (int k = 0; k < NI; k++) chk_out(k, 2, 64'd1 << (WS[k] - 1), 1'b0);
      tick();
      tick();

      // Downstream stall during a 4-operand burst
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < NI; k++) din[k] = 64'd5 << (WS[k] - 5 - 4 * i);
         vin = 1'b1;
         if (i == 2) begin
            check("stall_ready_c3", 64'(ordy[0]), 64'd0);
            check("stall_accepts", 64'(sbq[0].size()), 64'd2);
            tick();
            check("stall_ready_c4", 64'(ordy[0]), 64'd0);
            tick();
            rdy = 1'b1;
         end
         tick();
      end
      vin = 1'b0;
      repeat (4) tick();
      for (int k = 0; k < NI; k++) check($sformatf("burst_drained_w%0d", WS[k]), 64'(sbq[k].size()), 64'd0);

      // Reset with both stages occupied
      rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < NI; k++) din[k] = 64'd3 << i;
         vin = 1'b1;
         tick();
      end
      vin = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("midrst_valid_w%0d", WS[k]), 64'(ov[k]), 64'd0);
         check($sformatf("midrst_ready_w%0d", WS[k]), 64'(ordy[k]), 64'd1);
         sbq[k].delete();
         hold[k]   = 0;
         zmodel[k] = 0;
      end
      rst = 1'b0;
      rdy = 1'b1;
      repeat (5) tick();
      for (int k = 0; k < NI; k++) check($sformatf("postrst_idle_w%0d", WS[k]), 64'(ov[k]), 64'd0);

      // Random elastic traffic; operands held until accepted
      last_acc = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!vin || last_acc) begin
            vin = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NI; k++) begin
               din[k] = {$urandom, $urandom} & ((64'd1 << WS[k]) - 64'd1);
               din[k] = din[k] >> $urandom_range(0, WS[k]);
            end
         end
         rdy = ($urandom_range(0, 2) != 0);
         tick();
      end
      vin = 1'b0;
      rdy = 1'b1;
      repeat (4) tick();
      for (int k = 0; k < NI; k++) check($sformatf("rand_drained_w%0d", WS[k]), 64'(sbq[k].size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
